mem_wb_pipe: RTL and testbench

MEM_WB_PIPE -- requirements
Module: mem_wb_pipe

---
 rtl/mem_wb_pipe.sv | 154 +++++++++++++++
 tb/tb_mem_wb_pipe.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_pipe.sv
// mem_wb_pipe: MEM/WB pipeline stage with valid/ready handshake.
// Carries one control bundle, NLANES data lanes and a write-back address per
// entry. It also counts back-pressured cycles, saturating at 16'hFFFF.
// Optional feature: define MEM_WB_PIPE_SKID_EN for a 2-entry (head + skid)
// stage with a registered in_ready. The default build is a 1-entry stage
// with a combinational in_ready.
module mem_wb_pipe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NLANES = 3,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned CTRL_W = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CTRL_W-1:0]        in_ctrl,
  input  logic [NLANES*DATA_W-1:0] in_data,
  input  logic [ADDR_W-1:0]        in_wa,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CTRL_W-1:0]        out_ctrl,
  output logic [NLANES*DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0]        out_wa,
  output logic [15:0]              stall_cycles
);

  localparam int unsigned LANES_W = NLANES * DATA_W;
  localparam int unsigned ENT_W   = CTRL_W + LANES_W + ADDR_W;

  // Occupancy of the stage. S_FULL is reachable only with the skid entry.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_HEAD  = 2'd1,
    S_FULL  = 2'd2
  } occ_t;

  occ_t             state_q, state_d;
  logic [ENT_W-1:0] in_ent;
  logic [ENT_W-1:0] head_q, head_d;
  logic             push, pop;
  logic [15:0]      stall_q;

  // Each entry is packed as {ctrl, lanes, wa}, so its fields move together.
  assign in_ent    = {in_ctrl, in_data, in_wa};
  assign out_valid = (state_q != S_EMPTY);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready;

`ifdef MEM_WB_PIPE_SKID_EN
  logic [ENT_W-1:0] skid_q, skid_d;
  logic             ready_q;

  assign in_ready = ready_q;

  // Registered ready: it looks at the next occupancy only, so out_ready has
  // no combinational path to in_ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ready_q <= 1'b0;
    else       ready_q <= (state_d != S_FULL);
  end

  // Skid entry storage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) skid_q <= '0;
    else       skid_q <= skid_d;
  end
`else
  logic started_q;

  // in_ready stays low while reset is asserted. It may rise after the first
  // edge once reset is released.
  assign in_ready = started_q && (!out_valid || out_ready);

  // Tracks whether an edge has occurred since reset was released.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) started_q <= 1'b0;
    else       started_q <= 1'b1;
  end
`endif

  // Next occupancy and entry contents. Flush overrides everything; a head
  // retired on the same edge has already been delivered.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
`ifdef MEM_WB_PIPE_SKID_EN
    skid_d  = skid_q;
`endif
    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (push) begin
            head_d  = in_ent;
            state_d = S_HEAD;
          end
        end
        S_HEAD: begin
          if (push && pop) begin
            head_d = in_ent;
`ifdef MEM_WB_PIPE_SKID_EN
          end else if (push) begin
            skid_d  = in_ent;
            state_d = S_FULL;
`endif
          end else if (pop) begin
            state_d = S_EMPTY;
          end
        end
`ifdef MEM_WB_PIPE_SKID_EN
        S_FULL: begin
          if (pop) begin
            head_d  = skid_q;
            state_d = S_HEAD;
          end
        end
`endif
        default: state_d = S_EMPTY;
      endcase
    end
  end

  // Occupancy state and head entry registers. Asynchronous reset clears both.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_EMPTY;
      head_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
    end
  end

  // Saturating count of edges with out_valid=1 and out_ready=0.
  // Flush does not clear it; only reset does.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
    end else if (out_valid && !out_ready && (stall_q != '1)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  // Control is forced to zero for bubbles, so an empty slot never writes a
  // register or redirects the PC.
  assign out_ctrl     = out_valid ? head_q[ENT_W-1 -: CTRL_W] : '0;
  assign out_data     = head_q[ADDR_W +: LANES_W];
  assign out_wa       = head_q[ADDR_W-1:0];
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Testbench for mem_wb_pipe. It keeps a queue-based reference model of the
// stage and compares the DUT against it. Build with MEM_WB_PIPE_SKID_EN
// defined to check the 2-entry mode.
module tb_mem_wb_pipe;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   in_ctrl = '0;
  logic [95:0]  in_data = '0;
  logic [3:0]   in_wa = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [2:0]   out_ctrl;
  logic [95:0]  out_data;
  logic [3:0]   out_wa;
  logic [15:0]  stall_cycles;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [2:0]  ctrl;
    logic [95:0] data;
    logic [3:0]  wa;
  } ent_t;

  // Reference model: held entries in order, stall count, ready state.
  ent_t q[$];
  int   m_stall   = 0;
  bit   m_started = 0;
  bit   m_rdy     = 0;

  mem_wb_pipe #(.DATA_W(32), .NLANES(3), .ADDR_W(4), .CTRL_W(3)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .in_wa(in_wa),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_data(out_data), .out_wa(out_wa),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  function automatic bit m_in_ready();
`ifdef MEM_WB_PIPE_SKID_EN
    return m_rdy;
`else
    return m_started && (q.size() == 0 || out_ready);
`endif
  endfunction

  task automatic model_clear();
    q.delete();
    m_stall   = 0;
    m_started = 0;
    m_rdy     = 0;
  endtask

  // Advance one clock edge and apply the handshake rules to the model.
  task automatic tick();
    bit   pop, push;
    ent_t e;
    pop  = (q.size() > 0) && out_ready;
    push = in_valid && m_in_ready() && !flush;
    e    = '{in_ctrl, in_data, in_wa};
    if (q.size() > 0 && !out_ready && m_stall < 65535) m_stall++;
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (flush) q.delete();
    else if (push) q.push_back(e);
    m_started = 1;
    m_rdy     = (q.size() < 2);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
    tick();
  endtask

  task automatic rand_input(input logic [3:0] wa);
    in_ctrl = 3'($urandom);
    in_data = {$urandom, $urandom, $urandom};
    in_wa   = wa;
  endtask

  task automatic test_reset();
    in_valid = 1'b1; out_ready = 1'b1; rand_input(4'h3);
    #3;
    n_vec += 6;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b exp 0", out_valid); end
    if (out_ctrl !== 3'b0) begin n_err++; $display("FAIL rst_ctrl got %h exp 0", out_ctrl); end
    if (out_data !== 96'b0) begin n_err++; $display("FAIL rst_data got %h exp 0", out_data); end
    if (out_wa !== 4'b0) begin n_err++; $display("FAIL rst_wa got %h exp 0", out_wa); end
    if (stall_cycles !== 16'b0) begin n_err++; $display("FAIL rst_stall got %h exp 0", stall_cycles); end
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
    @(posedge clk);
    #1;
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_hold_valid got %b exp 0", out_valid); end
    reset = 1'b0; in_valid = 1'b0;
    model_clear();
    #1;
    n_vec++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_rel_ready got %b exp 0", in_ready); end
    tick();
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_first_edge_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_single();
    out_ready = 1'b1; in_valid = 1'b1;
    in_ctrl = 3'b111; in_wa = 4'hA;
    in_data = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    tick();
    in_valid = 1'b0;
    #1;
    n_vec += 4;
    if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid got %b exp 1", out_valid); end
    if (out_ctrl !== 3'b111) begin n_err++; $display("FAIL single_ctrl got %h exp 7", out_ctrl); end
    if (out_wa !== 4'hA) begin n_err++; $display("FAIL single_wa got %h exp a", out_wa); end
    if (out_data !== {32'h3333_3333, 32'h2222_2222, 32'h1111_1111}) begin
      n_err++; $display("FAIL single_data got %h exp 333333332222222211111111", out_data);
    end
    tick();
    n_vec += 2;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_after_valid got %b exp 0", out_valid); end
    if (out_ctrl !== 3'b0) begin n_err++; $display("FAIL single_after_ctrl got %h exp 0", out_ctrl); end
  endtask

  task automatic test_stream();
    int sent = 0, recv = 0;
    apply_reset();
    for (int c = 0; c < 40 && recv < 8; c++) begin
      in_valid  = (sent < 8);
      out_ready = !(c >= 3 && c <= 5);
      rand_input(4'(sent));
      #1;
      n_vec += 2;
      if (out_valid !== (q.size() > 0)) begin
        n_err++; $display("FAIL stream_valid c%0d got %b exp %b", c, out_valid, q.size() > 0);
      end
      if (in_ready !== m_in_ready()) begin
        n_err++; $display("FAIL stream_ready c%0d got %b exp %b", c, in_ready, m_in_ready());
      end
      if (out_valid && out_ready && q.size() > 0) begin
        n_vec += 2;
        if (out_wa !== 4'(recv)) begin n_err++; $display("FAIL stream_order got %h exp %h", out_wa, 4'(recv)); end
        if (out_data !== q[0].data) begin n_err++; $display("FAIL stream_data got %h exp %h", out_data, q[0].data); end
        recv++;
      end
      if (in_valid && m_in_ready()) sent++;
      tick();
    end
    in_valid = 1'b0;
    n_vec += 2;
    if (recv != 8) begin n_err++; $display("FAIL stream_count got %0d exp 8", recv); end
    if (stall_cycles !== 16'd3) begin n_err++; $display("FAIL stream_stall got %0d exp 3", stall_cycles); end
  endtask

  task automatic test_flush();
    int n;
`ifdef MEM_WB_PIPE_SKID_EN
    n = 2;
`else
    n = 1;
`endif
    apply_reset();
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1; rand_input(4'(i));
      tick();
    end
    n_vec++;
    if (out_valid !== 1'b1) begin n_err++; $display("FAIL flush_fill got %b exp 1", out_valid); end
    flush = 1'b1; in_valid = 1'b1; in_ctrl = 3'b101; in_wa = 4'hF; in_data = {3{32'hDEAD_BEEF}};
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    n_vec += 2;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid got %b exp 0", out_valid); end
    if (out_ctrl !== 3'b0) begin n_err++; $display("FAIL flush_ctrl got %h exp 0", out_ctrl); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_leak got %b exp 0 wa %h", out_valid, out_wa); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; rand_input(4'(i));
      #1;
      n_vec++;
      if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready i%0d got %b exp 1", i, in_ready); end
      if (i > 0) begin
        n_vec += 2;
        if (out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid i%0d got %b exp 1", i, out_valid); end
        if (out_wa !== 4'(i - 1)) begin n_err++; $display("FAIL b2b_wa i%0d got %h exp %h", i, out_wa, 4'(i - 1)); end
        if (q.size() > 0) begin
          n_vec++;
          if (out_data !== q[0].data) begin n_err++; $display("FAIL b2b_data got %h exp %h", out_data, q[0].data); end
        end
      end
      tick();
    end
    in_valid = 1'b0;
    tick(); tick();
  endtask

  task automatic test_random();
    bit exp_v;
    logic [2:0] exp_ctrl;
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 29) == 0);
      rand_input(4'($urandom));
      #1;
      exp_v    = (q.size() > 0);
      exp_ctrl = 3'b0;
      if (exp_v) exp_ctrl = q[0].ctrl;
      n_vec += 4;
      if (out_valid !== exp_v) begin n_err++; $display("FAIL rnd_valid c%0d got %b exp %b", c, out_valid, exp_v); end
      if (out_ctrl !== exp_ctrl) begin n_err++; $display("FAIL rnd_ctrl c%0d got %h exp %h", c, out_ctrl, exp_ctrl); end
      if (in_ready !== m_in_ready()) begin n_err++; $display("FAIL rnd_ready c%0d got %b exp %b", c, in_ready, m_in_ready()); end
      if (stall_cycles !== 16'(m_stall)) begin n_err++; $display("FAIL rnd_stall c%0d got %0d exp %0d", c, stall_cycles, m_stall); end
      if (exp_v) begin
        n_vec += 2;
        if (out_wa !== q[0].wa) begin n_err++; $display("FAIL rnd_wa c%0d got %h exp %h", c, out_wa, q[0].wa); end
        if (out_data !== q[0].data) begin n_err++; $display("FAIL rnd_data c%0d got %h exp %h", c, out_data, q[0].data); end
      end
      tick();
    end
    flush = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [95:0] d;
    apply_reset();
    out_ready = 1'b0; in_valid = 1'b1;
    rand_input(4'h1); tick();
    rand_input(4'h2); tick();
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    n_vec += 6;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL arst_valid got %b exp 0", out_valid); end
    if (out_ctrl !== 3'b0) begin n_err++; $display("FAIL arst_ctrl got %h exp 0", out_ctrl); end
    if (out_data !== 96'b0) begin n_err++; $display("FAIL arst_data got %h exp 0", out_data); end
    if (out_wa !== 4'b0) begin n_err++; $display("FAIL arst_wa got %h exp 0", out_wa); end
    if (stall_cycles !== 16'b0) begin n_err++; $display("FAIL arst_stall got %h exp 0", stall_cycles); end
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL arst_ready got %b exp 0", in_ready); end
    @(posedge clk);
    #3;
    reset = 1'b0; out_ready = 1'b1;
    model_clear();
    tick();
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL arst_resume_ready got %b exp 1", in_ready); end
    in_valid = 1'b1; rand_input(4'h5); d = in_data;
    tick();
    in_valid = 1'b0;
    #1;
    n_vec += 3;
    if (out_valid !== 1'b1) begin n_err++; $display("FAIL arst_xfer_valid got %b exp 1", out_valid); end
    if (out_wa !== 4'h5) begin n_err++; $display("FAIL arst_xfer_wa got %h exp 5", out_wa); end
    if (out_data !== d) begin n_err++; $display("FAIL arst_xfer_data got %h exp %h", out_data, d); end
    tick();
  endtask

  task automatic test_stall_saturate();
    apply_reset();
    out_ready = 1'b0; in_valid = 1'b1; rand_input(4'h9);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 70000; i++) begin
      tick();
      if (i == 999) begin
        n_vec++;
        if (stall_cycles !== 16'(m_stall)) begin n_err++; $display("FAIL sat_mid got %0d exp %0d", stall_cycles, m_stall); end
      end
    end
    n_vec += 3;
    if (stall_cycles !== 16'hFFFF) begin n_err++; $display("FAIL sat_value got %h exp ffff", stall_cycles); end
    if (out_valid !== 1'b1) begin n_err++; $display("FAIL sat_hold_valid got %b exp 1", out_valid); end
    if (out_wa !== 4'h9) begin n_err++; $display("FAIL sat_hold_wa got %h exp 9", out_wa); end
    for (int i = 0; i < 10; i++) tick();
    n_vec++;
    if (stall_cycles !== 16'hFFFF) begin n_err++; $display("FAIL sat_stay got %h exp ffff", stall_cycles); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_flush();
    test_back_to_back();
    test_random();
    test_async_reset();
    test_stall_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
